fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Streams a block of FIR tap coefficients from a CPU-writable buffer into the `cfg_din`/`cfg_ce` coefficient shift chain of a `fir_filter`. Software writes taps h[0]..h[N-1] by address, reads the filter's `len`, and pulses `start`. The loader then shifts exactly `fir_len` coefficients out in reverse order, so that tap h[k] lands in filter stage k+1 (the stage fed by the input delayed k samples). It sits between the CPU register bank and one `fir_filter` instance, on that filter's configuration clock.

## Interface
- `MAX_LEN`, 64: buffer depth; the largest filter this loader can program.
- `COEF_W`, 25: coefficient width; matches the filter's `cfg_din` width.
- `ADDR_W`, $clog2(MAX_LEN): buffer address width.
- `GAP`, 0: number of idle cycles inserted between consecutive `cfg_ce` pulses (0 = back-to-back).
- `clk`  in  1  the single clock; connected to the filter's `cfg_clk`.
- `reset`  in  1  synchronous, active-high; connected alongside the filter's `cfg_reset`.
- `wr_en`  in  1  CPU buffer write strobe.
- `wr_addr`  in  ADDR_W  buffer address; address k holds h[k].
- `wr_data`  in  COEF_W  coefficient value.
- `fir_len`  in  32  tap count reported by the filter's `len` output.
- `start`  in  1  single-cycle request to begin a load.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes or is rejected.
- `err`  out  1  sticky flag: the last start had `fir_len` > `MAX_LEN`.
- `cfg_dout`  out  COEF_W  coefficient to the filter's `cfg_din`.
- `cfg_ce`  out  1  shift enable to the filter's `cfg_ce`.

## Operation
- Buffer: `MAX_LEN` x `COEF_W` with a registered read. It is not cleared by `reset`, and its contents survive reset.
- CPU writes:
  - Accepted when `wr_en`=1, `busy`=0, and `wr_addr` < `MAX_LEN`.
  - Ignored while `busy`=1 or when `wr_addr` >= `MAX_LEN`.
- FSM states: IDLE, PREFETCH, SHIFT, GAP_WAIT, FINISH.
- **IDLE**:
  - `start`=1 with `fir_len`=0: go to FINISH; `err` <= 0; no shifts.
  - `start`=1 with `fir_len` > `MAX_LEN`: go to FINISH; `err` <= 1; no shifts.
  - Any other `start`=1: `err` <= 0; latch count N = `fir_len`; read address <= N-1; go to PREFETCH.
- **PREFETCH**: the buffer read is in flight. Go to SHIFT.
- **SHIFT**:
  - `cfg_ce`=1 with `cfg_dout` = buffer[addr]; decrement the remaining count.
  - If this was the last coefficient: go to FINISH.
  - Else if `GAP`=0: decrement addr and issue the next read so data is ready next cycle; stay in SHIFT.
  - Else: go to GAP_WAIT.
- **GAP_WAIT**:
  - Counts `GAP` cycles with `cfg_ce`=0.
  - The read address is decremented and the read issued so that data is valid on re-entry to SHIFT.
- **FINISH**: `done`=1 for one cycle, then IDLE.
- Order rule: the first `cfg_ce` carries h[N-1] and the last carries h[0].
- `start` while `busy`=1 is ignored; no queuing.
- `fir_len` is sampled only on the accepted `start` cycle.
- `cfg_dout` holds its last value when `cfg_ce`=0. The filter qualifies data with `cfg_ce` only.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `cfg_ce`=0, `cfg_dout`=0, FSM in IDLE.
- All outputs are registered.
- Normal load with `start` sampled high at edge T:
  - `busy`=1 from T+1 until the FINISH cycle inclusive; it falls the cycle after `done`.
  - First `cfg_ce` at T+2.
- `GAP`=0: `cfg_ce` is high for exactly N consecutive cycles (T+2 .. T+N+1), and `done` at T+N+2.
- General `GAP`: `cfg_ce` pulses are spaced `GAP`+1 cycles apart, and `done` comes one cycle after the last pulse. Total from T: 2 + N + (N-1)·`GAP` cycles to `done`.
- Rejected or zero-length start: `busy`=1 and `done`=1 both at T+1 (FINISH); IDLE at T+2; `cfg_ce` never asserts.
- Reset mid-load:
  - Outputs return to reset values on the next edge and the FSM goes to IDLE.
  - The filter is left partially shifted; software must reload it.
- `wr_en` and `start` in the same IDLE cycle: the write completes, and the load reads the updated word.

## Test plan
- **Load and order**: write h[k]=k+1 for k=0..20, `fir_len`=21, `start` -> 21 consecutive `cfg_ce` cycles with `cfg_dout` = 21,20,...,1; `done` one cycle after the last; `err`=0.
- **Gap pacing**: `GAP`=2, `fir_len`=4, h=[10,20,30,40] -> `cfg_ce` at T+2, T+5, T+8, T+11 carrying 40,30,20,10; `done` at T+12.
- **Boundary lengths**:
  - `fir_len`=0 -> `done` at T+1, no `cfg_ce`, `err`=0.
  - `fir_len`=`MAX_LEN`+1 -> `done` at T+1, `err`=1.
  - A following valid start clears `err`.
- **Ignored requests**: `wr_en` to address 3 and a second `start` during a 21-tap load -> buffer[3] unchanged, exactly 21 `cfg_ce` cycles, a single `done`.
- **Reset mid-load**: assert `reset` after the 5th `cfg_ce` -> `cfg_ce`=0, `busy`=0 the next cycle; buffer contents intact; a restarted load emits the full 21-value sequence.
- **End-to-end with `fir_filter`**: load h=[1<<23, 0, ..., 0] (unity at tap 0), drive an impulse into the filter -> the filter output reproduces the impulse at zero tap delay.

Source files
------------

// File: rtl/fir_coef_loader.sv
// Buffers FIR taps written by the CPU and shifts them into a filter's coefficient chain, h[N-1] first.
// Start-to-first cfg_ce is 2 cycles; there is no backpressure: writes and starts are dropped while busy.
module fir_coef_loader #(
  parameter int MAX_LEN = 64,
  parameter int COEF_W  = 25,
  parameter int ADDR_W  = $clog2(MAX_LEN),
  parameter int GAP     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [31:0]       fir_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [COEF_W-1:0] cfg_dout,
  output logic              cfg_ce
);

  typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, GAP_WAIT, FINISH} state_t;

  state_t            state, state_nxt;
  logic [COEF_W-1:0] mem [MAX_LEN];
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [ADDR_W:0]   remaining, remaining_nxt;
  logic [31:0]       gap_cnt, gap_cnt_nxt;
  logic              err_nxt;
  logic              wr_ok;

  assign wr_ok = wr_en && (state == IDLE) && (32'(wr_addr) < 32'(MAX_LEN));

  // Coefficient storage deliberately has no reset so taps survive a reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_nxt     = state;
    rd_addr_nxt   = rd_addr;
    remaining_nxt = remaining;
    gap_cnt_nxt   = gap_cnt;
    err_nxt       = err;
    case (state)
      IDLE: begin
        if (start) begin
          if (fir_len == 32'd0) begin
            state_nxt = FINISH;
            err_nxt   = 1'b0;
          end else if (fir_len > 32'(MAX_LEN)) begin
            state_nxt = FINISH;
            err_nxt   = 1'b1;
          end else begin
            err_nxt       = 1'b0;
            remaining_nxt = fir_len[ADDR_W:0];
            rd_addr_nxt   = fir_len[ADDR_W-1:0] - 1'b1;
            state_nxt     = PREFETCH;
          end
        end
      end
      PREFETCH: state_nxt = SHIFT;
      SHIFT: begin
        remaining_nxt = remaining - 1'b1;
        if (remaining == 1) begin
          state_nxt = FINISH;
        end else begin
          rd_addr_nxt = rd_addr - 1'b1;
          if (GAP == 0) begin
            state_nxt = SHIFT;
          end else begin
            state_nxt   = GAP_WAIT;
            gap_cnt_nxt = 32'(GAP - 1);
          end
        end
      end
      GAP_WAIT: begin
        if (gap_cnt == 32'd0) state_nxt = SHIFT;
        else                  gap_cnt_nxt = gap_cnt - 32'd1;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state; cfg_dout doubles as the buffer read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ce    <= 1'b0;
      cfg_dout  <= '0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= rd_addr_nxt;
      remaining <= remaining_nxt;
      gap_cnt   <= gap_cnt_nxt;
      err       <= err_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == FINISH);
      cfg_ce    <= (state_nxt == SHIFT);
      if (state_nxt == SHIFT) cfg_dout <= mem[rd_addr_nxt];
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: a timeline model checks the GAP=0 instance every cycle,
// literal expectations pin load order, pacing (GAP=2 instance), boundaries, reset and an impulse test.
module tb_fir_coef_loader;
  localparam int G_MAIN = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic [31:0] fir_len;
  logic        start, start_g;
  logic        busy, done, err, cfg_ce;
  logic [24:0] cfg_dout;
  logic        busy_g, done_g, err_g, cfg_ce_g;
  logic [24:0] cfg_dout_g;

  fir_coef_loader #(.GAP(G_MAIN)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fir_len(fir_len), .start(start), .busy(busy), .done(done), .err(err),
    .cfg_dout(cfg_dout), .cfg_ce(cfg_ce));

  fir_coef_loader #(.GAP(2)) dut_g (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fir_len(fir_len), .start(start_g), .busy(busy_g), .done(done_g), .err(err_g),
    .cfg_dout(cfg_dout_g), .cfg_ce(cfg_ce_g));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: a load accepted at edge T is busy for D cycles, pulses cfg_ce every G+1
  // cycles from T+2 carrying h[N-1]..h[0], and signals done in its final busy cycle.
  bit          m_act = 1'b0;
  int          m_T = 0, m_N = 0, m_D = 0;
  int          m_rst_edge = -1;
  logic        m_err = 1'b0;
  logic [24:0] m_last = '0;
  logic [24:0] m_buf [64];

  function automatic bit exp_busy(int j);
    return m_act && j >= 0 && j < m_D;
  endfunction
  function automatic bit exp_done(int j);
    return m_act && j == m_D - 1;
  endfunction
  function automatic bit exp_ce(int j);
    return m_act && m_N > 0 && j >= 1 && ((j - 1) % (G_MAIN + 1)) == 0 && ((j - 1) / (G_MAIN + 1)) < m_N;
  endfunction
  function automatic logic [24:0] exp_dout(int j);
    if (exp_ce(j))                 return m_buf[m_N - 1 - (j - 1) / (G_MAIN + 1)];
    else if (m_rst_edge == edge_cnt) return '0;
    else                           return m_last;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act      <= 1'b0;
      m_err      <= 1'b0;
      m_rst_edge <= edge_cnt + 1;
    end else if (!exp_busy(edge_cnt - m_T)) begin
      if (wr_en) m_buf[wr_addr] <= wr_data;
      if (start) begin
        m_act <= 1'b1;
        m_T   <= edge_cnt + 1;
        if (fir_len == 0 || fir_len > 64) begin
          m_N   <= 0;
          m_D   <= 1;
          m_err <= (fir_len > 64);
        end else begin
          m_N   <= int'(fir_len);
          m_D   <= 2 + int'(fir_len) + (int'(fir_len) - 1) * G_MAIN;
          m_err <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy(edge_cnt - m_T)));
      chk("done", 32'(done), 32'(exp_done(edge_cnt - m_T)));
      chk("err", 32'(err), 32'(m_err));
      chk("cfg_ce", 32'(cfg_ce), 32'(exp_ce(edge_cnt - m_T)));
      chk("cfg_dout", 32'(cfg_dout), 32'(exp_dout(edge_cnt - m_T)));
      m_last <= exp_dout(edge_cnt - m_T);
    end
  end

  // Event logs, times in the "sampled at edge T+k" numbering.
  int          ce_t[$], done_t[$], gce_t[$], gdone_t[$];
  logic [24:0] ce_v[$], gce_v[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (cfg_ce)   begin ce_t.push_back(edge_cnt + 1);  ce_v.push_back(cfg_dout);    end
      if (done)     done_t.push_back(edge_cnt + 1);
      if (cfg_ce_g) begin gce_t.push_back(edge_cnt + 1); gce_v.push_back(cfg_dout_g); end
      if (done_g)   gdone_t.push_back(edge_cnt + 1);
    end
  end

  // Downstream filter coefficient chain: h[k] ends up in chain[k].
  logic [24:0] chain [64];
  always @(posedge clk) begin
    if (cfg_ce) begin
      chain[0] <= cfg_dout;
      for (int i = 1; i < 64; i++) chain[i] <= chain[i-1];
    end
  end

  function automatic longint fir_impulse_y(int n, int taps);
    longint acc = 0;
    for (int k = 0; k < taps; k++)
      if (n - k == 0) acc += longint'(chain[k]);
    return acc;
  endfunction

  task automatic clear_logs();
    ce_t.delete(); ce_v.delete(); done_t.delete();
    gce_t.delete(); gce_v.delete(); gdone_t.delete();
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = 25'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int n, input bit on_gap, output int t);
    @(negedge clk);
    if (on_gap) start_g = 1'b1; else start = 1'b1;
    fir_len = 32'(n);
    t = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0; start_g = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy || busy_g); i++) @(negedge clk);
    chk("idle_timeout", 32'(busy | busy_g), 32'd0);
  endtask

  task automatic chk_desc(input int n, input int t);
    chk("ce_count", ce_v.size(), n);
    for (int i = 0; i < n && i < ce_v.size(); i++) chk("order", 32'(ce_v[i]), n - i);
    if (ce_t.size() > 0) chk("first_ce_time", ce_t[0], t + 2);
    chk("done_count", done_t.size(), 1);
    if (done_t.size() > 0) chk("done_time", done_t[0], t + n + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, cnt;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    fir_len = '0; start = 1'b0; start_g = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ce", 32'(cfg_ce), 0);
    chk("rst_dout", 32'(cfg_dout), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;

    // Load and order
    for (int k = 0; k < 21; k++) wr(k, k + 1);
    clear_logs(); do_start(21, 1'b0, t); wait_idle();
    chk_desc(21, t);
    chk("err_after_load", 32'(err), 0);

    // Boundary lengths
    clear_logs(); do_start(0, 1'b0, t); wait_idle();
    chk("zero_ce", ce_v.size(), 0);
    if (done_t.size() > 0) chk("zero_done_time", done_t[0], t + 1);
    else chk("zero_done_seen", 0, 1);
    chk("zero_err", 32'(err), 0);
    clear_logs(); do_start(65, 1'b0, t); wait_idle();
    chk("over_ce", ce_v.size(), 0);
    if (done_t.size() > 0) chk("over_done_time", done_t[0], t + 1);
    else chk("over_done_seen", 0, 1);
    chk("over_err", 32'(err), 1);
    clear_logs(); do_start(3, 1'b0, t); wait_idle();
    chk_desc(3, t);
    chk("err_cleared", 32'(err), 0);

    // Ignored write and start while busy
    clear_logs(); do_start(21, 1'b0, t);
    repeat (3) @(negedge clk);
    wr(3, 999);
    start = 1'b1; fir_len = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk_desc(21, t);
    clear_logs(); do_start(21, 1'b0, t); wait_idle();
    if (ce_v.size() > 17) chk("h3_kept", 32'(ce_v[17]), 4);
    else chk("h3_seen", ce_v.size(), 18);

    // Reset mid-load
    clear_logs(); do_start(21, 1'b0, t);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 5; i++) begin
      if (cfg_ce) cnt++;
      if (cnt < 5) @(negedge clk);
    end
    chk("fifth_ce_reached", cnt, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ce", 32'(cfg_ce), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    clear_logs(); do_start(21, 1'b0, t); wait_idle();
    chk_desc(21, t);

    // Write and start in the same idle cycle
    clear_logs();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'd2; wr_data = 25'd77; start = 1'b1; fir_len = 32'd3;
    t = edge_cnt + 1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_idle();
    chk("same_cycle_count", ce_v.size(), 3);
    if (ce_v.size() == 3) begin
      chk("same_cycle_h2", 32'(ce_v[0]), 77);
      chk("same_cycle_h1", 32'(ce_v[1]), 2);
      chk("same_cycle_h0", 32'(ce_v[2]), 1);
    end

    // Gap pacing on the GAP=2 instance
    for (int k = 0; k < 4; k++) wr(k, 10 * (k + 1));
    clear_logs(); do_start(4, 1'b1, t); wait_idle();
    chk("gap_ce_count", gce_v.size(), 4);
    for (int i = 0; i < 4 && i < gce_v.size(); i++) begin
      chk("gap_ce_time", gce_t[i], t + 2 + 3 * i);
      chk("gap_ce_val", 32'(gce_v[i]), 40 - 10 * i);
    end
    chk("gap_done_count", gdone_t.size(), 1);
    if (gdone_t.size() > 0) chk("gap_done_time", gdone_t[0], t + 12);

    // Impulse through the loaded chain: unity at tap 0
    wr(0, 1 << 23);
    for (int k = 1; k < 8; k++) wr(k, 0);
    clear_logs(); do_start(8, 1'b0, t); wait_idle();
    chk("impulse_y0", 32'(fir_impulse_y(0, 8)), 32'd8388608);
    for (int n = 1; n < 8; n++) chk("impulse_tail", 32'(fir_impulse_y(n, 8)), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
